// File: rtl/marquee_pkg.sv
// Shared character codes and the default message for the marquee display path.
package marquee_pkg;

    typedef enum logic [2:0] {
        CH_E     = 3'b000,
        CH_H     = 3'b001,
        CH_N     = 3'b010,
        CH_T     = 3'b011,
        CH_U     = 3'b100,
        CH_C     = 3'b101,
        CH_S     = 3'b110,
        CH_BLANK = 3'b111
    } char_e;

    localparam int DEFAULT_NUM_CHAR = 8;

    // Index 0 of the array lands in the least significant code of the result.
    function automatic logic [DEFAULT_NUM_CHAR*3-1:0] pack_msg(input char_e msg [DEFAULT_NUM_CHAR]);
        logic [DEFAULT_NUM_CHAR*3-1:0] res;
        res = '0;
        for (int i = 0; i < DEFAULT_NUM_CHAR; i++) begin
            res[i*3 +: 3] = msg[i];
        end
        return res;
    endfunction

    // "ntHUEECS" with slot 7 in the MSBs.
    localparam logic [DEFAULT_NUM_CHAR*3-1:0] DEFAULT_INIT =
        {CH_N, CH_T, CH_H, CH_U, CH_E, CH_E, CH_C, CH_S};

endpackage

// File: rtl/marquee_shift_if.sv
// Control, write and display bundle between a marquee controller and marquee_shift.
interface marquee_shift_if #(
    parameter int NUM_CHAR  = 8,
    parameter int CODE_W    = 3,
    parameter int NUM_DIGIT = 4,
    parameter int OUT_W     = 4,
    parameter int DIV_W     = 24
);
    localparam int ADDR_W = $clog2(NUM_CHAR);

    logic                       en;
    logic                       dir;
    logic                       mode;
    logic [DIV_W-1:0]           step_div;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [CODE_W-1:0]          wr_data;
    logic [NUM_DIGIT*OUT_W-1:0] digit_out;
    logic                       tick;
    logic [ADDR_W-1:0]          pos;
    logic                       wrap;

    modport master (
        output en, dir, mode, step_div, wr_en, wr_addr, wr_data,
        input  digit_out, tick, pos, wrap
    );

    modport slave (
        input  en, dir, mode, step_div, wr_en, wr_addr, wr_data,
        output digit_out, tick, pos, wrap
    );

endinterface

// File: rtl/step_prescaler.sv
// Free-running step prescaler: fires once every step_div+1 enabled cycles.
module step_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] step_div,
    output logic             step
);
    logic [DIV_W-1:0] cnt_reg;

    // >= rather than == so lowering step_div below the count fires at once.
    assign step = en && (cnt_reg >= step_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (step) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/marquee_shift.sv
// Rotating/shifting character message with a programmable step rate and a visible digit window.
module marquee_shift
    import marquee_pkg::*;
#(
    parameter int                NUM_CHAR   = 8,
    parameter int                CODE_W     = 3,
    parameter int                NUM_DIGIT  = 4,
    parameter int                OUT_W      = 4,
    parameter int                DIV_W      = 24,
    parameter logic [CODE_W-1:0] BLANK_CODE = CH_BLANK,
    parameter                    INIT       = DEFAULT_INIT
) (
    input  logic           clk,
    input  logic           rst_n,
    marquee_shift_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_CHAR);

    if (NUM_CHAR < 2) begin : g_chk_nchar
        $error("marquee_shift: NUM_CHAR must be at least 2");
    end
    if (NUM_DIGIT < 1 || NUM_DIGIT > NUM_CHAR) begin : g_chk_ndigit
        $error("marquee_shift: NUM_DIGIT must be in 1..NUM_CHAR");
    end
    if (OUT_W < CODE_W) begin : g_chk_outw
        $error("marquee_shift: OUT_W must be at least CODE_W");
    end
    if ($bits(INIT) != NUM_CHAR*CODE_W) begin : g_chk_init
        $error("marquee_shift: INIT width must equal NUM_CHAR*CODE_W");
    end

    logic [CODE_W-1:0] slot_reg  [NUM_CHAR];
    logic [CODE_W-1:0] slot_next [NUM_CHAR];
    logic [ADDR_W-1:0] pos_reg;
    logic [ADDR_W-1:0] pos_next;
    logic              wrap_next;
    logic              tick_reg;
    logic              wrap_reg;
    logic              step;

    step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .step_div (bus.step_div),
        .step     (step)
    );

    for (genvar gi = 0; gi < NUM_CHAR; gi++) begin : g_slot
        logic [CODE_W-1:0] left_src;
        logic [CODE_W-1:0] right_src;
        logic [CODE_W-1:0] shifted;

        if (gi == 0) begin : g_left_end
            assign left_src = bus.mode ? BLANK_CODE : slot_reg[NUM_CHAR-1];
        end else begin : g_left_mid
            assign left_src = slot_reg[gi-1];
        end

        if (gi == NUM_CHAR-1) begin : g_right_end
            assign right_src = bus.mode ? BLANK_CODE : slot_reg[0];
        end else begin : g_right_mid
            assign right_src = slot_reg[gi+1];
        end

        assign shifted = bus.dir ? right_src : left_src;

        // A coincident write lands on top of the already-shifted slot.
        always_comb begin
            slot_next[gi] = step ? shifted : slot_reg[gi];
            if (bus.wr_en && (bus.wr_addr == ADDR_W'(gi))) begin
                slot_next[gi] = bus.wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_reg[gi] <= INIT[gi*CODE_W +: CODE_W];
            end else begin
                slot_reg[gi] <= slot_next[gi];
            end
        end
    end

    always_comb begin
        pos_next  = pos_reg;
        wrap_next = 1'b0;
        if (step) begin
            if (bus.dir) begin
                wrap_next = (pos_reg == '0);
                pos_next  = wrap_next ? ADDR_W'(NUM_CHAR-1) : pos_reg - ADDR_W'(1);
            end else begin
                wrap_next = (pos_reg == ADDR_W'(NUM_CHAR-1));
                pos_next  = wrap_next ? '0 : pos_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg  <= '0;
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end else begin
            pos_reg  <= pos_next;
            tick_reg <= step;
            wrap_reg <= wrap_next;
        end
    end

    for (genvar gi = 0; gi < NUM_DIGIT; gi++) begin : g_digit
        assign bus.digit_out[gi*OUT_W +: OUT_W] = OUT_W'(slot_reg[NUM_CHAR-NUM_DIGIT+gi]);
    end

    assign bus.tick = tick_reg;
    assign bus.pos  = pos_reg;
    assign bus.wrap = wrap_reg;

endmodule
